// File: rtl/rng_buffer.sv
// First-word-fall-through buffer between a random generator and its consumer, with drop counting.
// Optional repetition health test compiled in with `define RNG_HEALTH_REP_TEST_EN.
module rng_buffer #(
    parameter int DEPTH     = 8,
    parameter int REP_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                in_data,
    input  logic                       in_valid,
    output logic [31:0]                out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                drop_cnt,
    output logic                       health_fail
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rng_buffer: DEPTH must be a power of two from 2 to 64");
    end
    if (REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_bad_rep
        $error("rng_buffer: REP_LIMIT must be 2 to 255");
    end

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [15:0]   r_drop_cnt;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_blocked;

    assign w_full = (r_level == LVL_FULL);
    assign w_pop  = (r_level != '0) && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the word.
    assign w_push = in_valid && (!w_full || w_pop) && !w_blocked;
    assign w_drop = in_valid && w_full && !w_pop && !w_blocked;

`ifdef RNG_HEALTH_REP_TEST_EN
    localparam logic [7:0] REP_MAX = 8'(REP_LIMIT);

    logic [7:0]  r_rep_cnt;
    logic [31:0] r_last_word;
    logic        r_health_fail;
    logic [7:0]  w_rep_next;
    logic        w_trip;

    // Next repetition count; a zero count marks "no previous word since reset".
    always_comb begin
        w_rep_next = r_rep_cnt;
        if (in_valid) begin
            if (r_rep_cnt != 8'd0 && in_data == r_last_word) begin
                if (r_rep_cnt >= REP_MAX) begin
                    w_rep_next = REP_MAX;
                end else begin
                    w_rep_next = r_rep_cnt + 8'd1;
                end
            end else begin
                w_rep_next = 8'd1;
            end
        end else begin
            w_rep_next = r_rep_cnt;
        end
    end

    assign w_trip    = in_valid && (w_rep_next == REP_MAX);
    assign w_blocked = r_health_fail || w_trip;

    // Repetition tracker and sticky failure flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rep_cnt     <= 8'd0;
            r_last_word   <= 32'h0;
            r_health_fail <= 1'b0;
        end else begin
            r_rep_cnt <= w_rep_next;
            if (in_valid) begin
                r_last_word <= in_data;
            end
            if (w_trip) begin
                r_health_fail <= 1'b1;
            end
        end
    end

    assign health_fail = r_health_fail;
`else
    assign w_blocked   = 1'b0;
    assign health_fail = 1'b0;
`endif

    // Storage array; contents need no reset because the pointers and level gate visibility.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and drop counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_drop_cnt <= 16'h0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign out_valid = (r_level != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : 32'h0;
    assign level     = r_level;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_rng_buffer.sv
// Directed self-checking bench for rng_buffer (DEPTH=8, REP_LIMIT=4); health checks follow the macro.
module tb_rng_buffer;
    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  level;
    logic [15:0] drop_cnt;
    logic        health_fail;

    int total;
    int bad;

    rng_buffer #(.DEPTH(8), .REP_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .drop_cnt(drop_cnt), .health_fail(health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b1;
        tick();
        tick();
        total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%0h exp=0", out_data); end
        total++; if (drop_cnt !== 16'h0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL reset_health got=%0b exp=0", health_fail); end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; in_data = 32'(k);
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin bad++; $display("FAIL basic_fwft got=%0b/%0h exp=1/1", out_valid, out_data); end
        end
        in_valid = 1'b0;
        total++; if (level !== 4'd3) begin bad++; $display("FAIL basic_level got=%0d exp=3", level); end
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            total++; if (out_valid !== 1'b1 || out_data !== 32'(k)) begin bad++; $display("FAIL basic_drain got=%0b/%0h exp=1/%0h", out_valid, out_data, k); end
            tick();
        end
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin bad++; $display("FAIL basic_empty got=%0b/%0h exp=0/0", out_valid, out_data); end
        tick();
        total++; if (level !== 4'd0) begin bad++; $display("FAIL basic_pop_empty got=%0d exp=0", level); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1; in_data = 32'h7; out_ready = 1'b1;
        tick();
        total++; if (level !== 4'd1 || out_data !== 32'h7) begin bad++; $display("FAIL b2b_first got=%0d/%0h exp=1/7", level, out_data); end
        in_data = 32'h8;
        tick();
        total++; if (level !== 4'd1 || out_data !== 32'h8) begin bad++; $display("FAIL b2b_lvl1 got=%0d/%0h exp=1/8", level, out_data); end
        in_valid = 1'b0;
        tick();
        total++; if (level !== 4'd0) begin bad++; $display("FAIL b2b_drain got=%0d exp=0", level); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = 32'(100 + k);
            tick();
        end
        total++; if (level !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d exp=8", level); end
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_drop got=%0d exp=2", drop_cnt); end
        total++; if (out_data !== 32'd100) begin bad++; $display("FAIL ovf_head got=%0d exp=100", out_data); end
        in_data = 32'd200; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (level !== 4'd8 || drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_full_pp got=%0d/%0d exp=8/2", level, drop_cnt); end
        for (int k = 1; k <= 8; k++) begin
            total++; if (out_data !== ((k == 8) ? 32'd200 : 32'(100 + k))) begin bad++; $display("FAIL ovf_wrap_drain got=%0d idx=%0d", out_data, k); end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 70008; k++) begin
            in_data = 32'(k + 1000);
            tick();
        end
        in_valid = 1'b0;
        total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_drop got=%0h exp=ffff", drop_cnt); end
        total++; if (level !== 4'd8) begin bad++; $display("FAIL sat_level got=%0d exp=8", level); end
    endtask

    task automatic test_health();
        logic [31:0] seq [6];
        seq[0] = 32'hA; seq[1] = 32'hB; seq[2] = 32'hB; seq[3] = 32'hB; seq[4] = 32'hB; seq[5] = 32'hC;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = seq[k];
            tick();
`ifdef RNG_HEALTH_REP_TEST_EN
            total++; if (health_fail !== (k >= 4)) begin bad++; $display("FAIL health_flag got=%0b idx=%0d", health_fail, k); end
`else
            total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL health_off got=%0b idx=%0d", health_fail, k); end
`endif
        end
        in_valid = 1'b0;
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL health_drop got=%0d exp=0", drop_cnt); end
`ifdef RNG_HEALTH_REP_TEST_EN
        total++; if (level !== 4'd4) begin bad++; $display("FAIL health_level got=%0d exp=4", level); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++; if (out_data !== seq[k]) begin bad++; $display("FAIL health_drain got=%0h exp=%0h", out_data, seq[k]); end
            tick();
        end
        total++; if (out_valid !== 1'b0 || health_fail !== 1'b1) begin bad++; $display("FAIL health_sticky got=%0b/%0b exp=0/1", out_valid, health_fail); end
`else
        total++; if (level !== 4'd6) begin bad++; $display("FAIL health_off_level got=%0d exp=6", level); end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            total++; if (out_data !== seq[k]) begin bad++; $display("FAIL health_off_drain got=%0h exp=%0h", out_data, seq[k]); end
            tick();
        end
`endif
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] seq [6];
        seq[0] = 32'h11; seq[1] = 32'h22; seq[2] = 32'hEE; seq[3] = 32'hEE; seq[4] = 32'hEE; seq[5] = 32'hEE;
        do_reset();
`ifdef RNG_HEALTH_REP_TEST_EN
        for (int k = 0; k < 6; k++) begin
`else
        for (int k = 0; k < 5; k++) begin
`endif
            in_valid = 1'b1; in_data = seq[k];
            tick();
        end
        total++; if (level !== 4'd5) begin bad++; $display("FAIL mid_pre_level got=%0d exp=5", level); end
`ifdef RNG_HEALTH_REP_TEST_EN
        total++; if (health_fail !== 1'b1) begin bad++; $display("FAIL mid_pre_health got=%0b exp=1", health_fail); end
`endif
        rst = 1'b0; in_data = 32'h99; out_ready = 1'b1;
        tick();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (level !== 4'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_level got=%0d/%0b exp=0/0", level, out_valid); end
        total++; if (drop_cnt !== 16'd0 || health_fail !== 1'b0) begin bad++; $display("FAIL mid_flags got=%0d/%0b exp=0/0", drop_cnt, health_fail); end
        in_valid = 1'b1; in_data = 32'h55;
        tick();
        in_valid = 1'b0;
        total++; if (level !== 4'd1 || out_data !== 32'h55) begin bad++; $display("FAIL mid_fresh got=%0d/%0h exp=1/55", level, out_data); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_health();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
